regfile_wb_arbiter: RTL and testbench

//   Shares the single RegisterFile write port (wsel/wdata/wen) between N_REQ

---
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the writeback requesters and the RegisterFile write port.
// The master side drives requests; the slave side (arbiter) grants them and drives the RF port.
interface regfile_wb_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int N_REQ = 2
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*AW-1:0]   req_sel;
    logic [N_REQ*XLEN-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  hold;
    logic [AW-1:0]         rf_wsel;
    logic [XLEN-1:0]       rf_wdata;
    logic                  rf_wen;
    logic [GW-1:0]         grant_id;

    modport master (
        output req_valid, req_sel, req_data, hold,
        input  req_ready, rf_wsel, rf_wdata, rf_wen, grant_id
    );

    modport slave (
        input  req_valid, req_sel, req_data, hold,
        output req_ready, rf_wsel, rf_wdata, rf_wen, grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one RegisterFile write port among N_REQ writeback sources.
// One registered output stage; writes aimed at x0 are accepted but never raise rf_wen.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int N_REQ = 2
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // ptr_r holds the index with highest priority for the next search.
    logic [GW-1:0]    ptr_r;
    logic [AW-1:0]    wsel_r;
    logic [XLEN-1:0]  wdata_r;
    logic             wen_r;
    logic [GW-1:0]    gid_r;

    logic             found_s;
    logic [GW-1:0]    win_s;
    logic             accept_s;
    logic [N_REQ-1:0] ready_s;
    logic [AW-1:0]    win_sel_s;
    logic [XLEN-1:0]  win_data_s;

    // Returns {found, index}; scanning from the far end lets the nearest valid overwrite.
    function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [GW-1:0]    ptr);
        logic [GW:0]   res;
        logic [GW-1:0] idx;
        res = {(GW+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(ptr) + k) % N_REQ);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Combinational grant: one-hot winner, suppressed by reset or hold.
    always_comb begin
        ready_s    = {N_REQ{1'b0}};
        {found_s, win_s} = rr_pick(bus.req_valid, ptr_r);
        accept_s   = found_s & ~bus.hold & ~rst;
        win_sel_s  = bus.req_sel[win_s*AW +: AW];
        win_data_s = bus.req_data[win_s*XLEN +: XLEN];
        if (accept_s) begin
            ready_s[win_s] = 1'b1;
        end else begin
            ready_s = {N_REQ{1'b0}};
        end
    end

    // Output stage and round-robin pointer; the pointer moves only on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= {GW{1'b0}};
            wsel_r  <= {AW{1'b0}};
            wdata_r <= {XLEN{1'b0}};
            wen_r   <= 1'b0;
            gid_r   <= {GW{1'b0}};
        end else if (accept_s) begin
            wsel_r  <= win_sel_s;
            wdata_r <= win_data_s;
            wen_r   <= (win_sel_s != {AW{1'b0}});
            gid_r   <= win_s;
            if (win_s == GW'(N_REQ - 1)) begin
                ptr_r <= {GW{1'b0}};
            end else begin
                ptr_r <= win_s + GW'(1);
            end
        end else begin
            wen_r <= 1'b0;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rf_wsel   = wsel_r;
    assign bus.rf_wdata  = wdata_r;
    assign bus.rf_wen    = wen_r;
    assign bus.grant_id  = gid_r;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter with a small RegisterFile model on the write port.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32, AW = 5, N_REQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [XLEN-1:0] rf [0:31];

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW), .N_REQ(N_REQ)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .N_REQ(N_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RegisterFile model: commits on the edge that sees wen, x0 reads as zero.
    always @(posedge clk) begin
        if (bus.rf_wen && bus.rf_wsel != 5'd0) rf[bus.rf_wsel] <= bus.rf_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] s0, input logic [31:0] d0,
                           input logic [4:0] s1, input logic [31:0] d1);
        bus.req_valid = v;
        bus.req_sel   = {s1, s0};
        bus.req_data  = {d1, d0};
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.hold = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(2'b11, 5'd3, 32'h1, 5'd4, 32'h2);
        step();
        step();
        n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", bus.rf_wen); end
        n_checks++; if (bus.rf_wsel !== 5'd0) begin n_fail++; $display("FAIL reset_wsel got=%0d exp=0", bus.rf_wsel); end
        n_checks++; if (bus.rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", bus.rf_wdata); end
        n_checks++; if (bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_gid got=%0d exp=0", bus.grant_id); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready); end
        bus.req_valid = 2'b00;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        #1;
        n_checks++; if (bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL single_wen got=%b exp=1", bus.rf_wen); end
        n_checks++; if (bus.rf_wsel !== 5'd5) begin n_fail++; $display("FAIL single_wsel got=%0d exp=5", bus.rf_wsel); end
        n_checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wdata got=%h exp=deadbeef", bus.rf_wdata); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL single_idle_ready got=%b exp=00", bus.req_ready); end
        step();
        n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_drop got=%b exp=0", bus.rf_wen); end
        n_checks++; if (bus.rf_wsel !== 5'd5) begin n_fail++; $display("FAIL single_wsel_hold got=%0d exp=5", bus.rf_wsel); end
        n_checks++; if (rf[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rf_x5 got=%h exp=deadbeef", rf[5]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_rdy;
        logic [4:0]  exp_sel;
        logic [31:0] exp_dat;
        do_reset();
        set_req(2'b11, 5'd10, 32'h12345678, 5'd15, 32'hAAAAAAAA);
        for (int c = 0; c < 4; c++) begin
            exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_sel = (c % 2 == 0) ? 5'd10 : 5'd15;
            exp_dat = (c % 2 == 0) ? 32'h12345678 : 32'hAAAAAAAA;
            n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
            step();
            n_checks++; if (bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL b2b_wen c=%0d got=%b exp=1", c, bus.rf_wen); end
            n_checks++; if (bus.grant_id !== 1'(c % 2)) begin n_fail++; $display("FAIL b2b_gid c=%0d got=%0d exp=%0d", c, bus.grant_id, c % 2); end
            n_checks++; if (bus.rf_wsel !== exp_sel || bus.rf_wdata !== exp_dat) begin n_fail++; $display("FAIL b2b_data c=%0d got=%0d/%h exp=%0d/%h", c, bus.rf_wsel, bus.rf_wdata, exp_sel, exp_dat); end
        end
        bus.req_valid = 2'b00;
        step();
        n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_wen got=%b exp=0", bus.rf_wen); end
        n_checks++; if (rf[10] !== 32'h12345678 || rf[15] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL b2b_rf got=%h/%h exp=12345678/aaaaaaaa", rf[10], rf[15]); end
    endtask

    task automatic test_x0();
        do_reset();
        set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'h1);
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL x0_ready got=%b exp=10", bus.req_ready); end
        step();
        n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen got=%b exp=0", bus.rf_wen); end
        n_checks++; if (bus.grant_id !== 1'b1) begin n_fail++; $display("FAIL x0_gid got=%0d exp=1", bus.grant_id); end
        set_req(2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL x0_next_ready got=%b exp=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        n_checks++; if (bus.grant_id !== 1'b0 || bus.rf_wen !== 1'b1 || bus.rf_wsel !== 5'd3) begin n_fail++; $display("FAIL x0_next_out got=%0d/%b/%0d exp=0/1/3", bus.grant_id, bus.rf_wen, bus.rf_wsel); end
    endtask

    task automatic test_hold();
        do_reset();
        set_req(2'b11, 5'd6, 32'h66, 5'd7, 32'h77);
        step();
        bus.hold = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_ready c=%0d got=%b exp=00", c, bus.req_ready); end
            step();
            n_checks++; if (bus.rf_wen !== 1'b0 || bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL hold_out c=%0d got=%b/%0d exp=0/0", c, bus.rf_wen, bus.grant_id); end
        end
        bus.hold = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL hold_resume_ready got=%b exp=10", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        n_checks++; if (bus.grant_id !== 1'b1 || bus.rf_wen !== 1'b1 || bus.rf_wdata !== 32'h77) begin n_fail++; $display("FAIL hold_resume_out got=%0d/%b/%h exp=1/1/77", bus.grant_id, bus.rf_wen, bus.rf_wdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2'b01, 5'd13, 32'h9, 5'd15, 32'h7);
        step();
        set_req(2'b10, 5'd13, 32'h9, 5'd15, 32'h7);
        step();
        n_checks++; if (bus.rf_wen !== 1'b1 || bus.grant_id !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b/%0d exp=1/1", bus.rf_wen, bus.grant_id); end
        rst = 1'b1;
        set_req(2'b01, 5'd15, 32'h1, 5'd15, 32'h1);
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=00", bus.req_ready); end
        step();
        n_checks++; if (bus.rf_wen !== 1'b0 || bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got=%b/%0d exp=0/0", bus.rf_wen, bus.grant_id); end
        step();
        n_checks++; if (rf[15] !== 32'h7) begin n_fail++; $display("FAIL rstmid_rf_x15 got=%h exp=7", rf[15]); end
        rst = 1'b0;
        set_req(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_after_ready got=%b exp=01", bus.req_ready); end
        bus.req_valid = 2'b00;
        #1;
    endtask

    task automatic test_reset_contention();
        do_reset();
        set_req(2'b01, 5'd8, 32'h8, 5'd9, 32'h9);
        step();
        rst = 1'b1;
        set_req(2'b11, 5'd8, 32'h8, 5'd9, 32'h9);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rstcont_ready c=%0d got=%b exp=00", c, bus.req_ready); end
            step();
            n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL rstcont_wen c=%0d got=%b exp=0", c, bus.rf_wen); end
        end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rstcont_ptr got=%b exp=01", bus.req_ready); end
        bus.req_valid = 2'b00;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        bus.req_valid = 2'b00;
        bus.req_sel   = '0;
        bus.req_data  = '0;
        bus.hold      = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_x0();
        test_hold();
        test_reset_mid();
        test_reset_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
